// File: rtl/cndm_micro_pkg.sv
// Shared types for the cndm micro DMA read scheduler.
// No logic; types and width limits only.
// Used by the scheduler top and its arbiter.
package cndm_micro_pkg;

  // Completion error code from the DMA read engine; zero means success.
  typedef enum logic [3:0] {
    DMA_ERR_OK       = 4'h0,
    DMA_ERR_TIMEOUT  = 4'h1,
    DMA_ERR_PARITY   = 4'h2,
    DMA_ERR_BAD_ADDR = 4'h3
  } dma_err_t;

  // Upper bounds for the engine-side tag split (client index, client tag).
  localparam int CL_MAX_W  = 8;
  localparam int TAG_MAX_W = 32;

  // Engine-side tag split into the owning client and that client's own tag.
  typedef struct packed {
    logic [CL_MAX_W-1:0]  client;
    logic [TAG_MAX_W-1:0] tag;
  } tag_split_t;

endpackage

// File: rtl/cndm_micro_rr_arb.sv
// Round-robin priority select: the first requester at or above ptr, wrapping.
// Latency: purely combinational.
// Backpressure: none; the caller qualifies the grant with its own load enable.
module cndm_micro_rr_arb
  import cndm_micro_pkg::*;
#(
  parameter int N = 2,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] gnt_idx,
  output logic         gnt_vld
);

  logic [W:0] pos;

  // Walk upward from ptr with wrap and take the first active requester.
  always_comb begin
    gnt_idx = '0;
    gnt_vld = 1'b0;
    pos     = '0;
    for (int k = 0; k < N; k++) begin
      pos = {1'b0, ptr} + (W+1)'(k);
      if (pos >= (W+1)'(N)) pos = pos - (W+1)'(N);
      if (!gnt_vld && req[pos[W-1:0]]) begin
        gnt_vld = 1'b1;
        gnt_idx = pos[W-1:0];
      end
    end
  end

endmodule

// File: rtl/cndm_micro_dma_rd_sched.sv
// Schedules per-client DMA read requests onto one engine (round-robin, credit-limited); optional CNDM_DMA_RD_SCHED_STATS_EN adds stats.
// Latency: request 1 cycle (one register slice), status 1 cycle (registered demux).
// Backpressure: ready to the granted client only while the slice is free; status path has none.
module cndm_micro_dma_rd_sched
  import cndm_micro_pkg::*;
#(
  parameter int CLIENTS         = 2,
  parameter int ADDR_W          = 64,
  parameter int LEN_W           = 16,
  parameter int TAG_W           = 8,
  parameter int MAX_OUTSTANDING = 4,
  localparam int CL_W = $clog2(CLIENTS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CLIENTS*ADDR_W-1:0] s_req_addr,
  input  logic [CLIENTS*LEN_W-1:0]  s_req_len,
  input  logic [CLIENTS*TAG_W-1:0]  s_req_tag,
  input  logic [CLIENTS-1:0]        s_req_valid,
  output logic [CLIENTS-1:0]        s_req_ready,
  output logic [ADDR_W-1:0]         m_req_addr,
  output logic [LEN_W-1:0]          m_req_len,
  output logic [TAG_W+CL_W-1:0]     m_req_tag,
  output logic                      m_req_valid,
  input  logic                      m_req_ready,
  input  logic [TAG_W+CL_W-1:0]     s_sts_tag,
  input  logic [3:0]                s_sts_error,
  input  logic                      s_sts_valid,
  output logic [TAG_W-1:0]          m_sts_tag,
  output logic [3:0]                m_sts_error,
  output logic [CLIENTS-1:0]        m_sts_valid,
  output logic                      busy,
  output logic                      err_underflow
`ifdef CNDM_DMA_RD_SCHED_STATS_EN
  ,
  output logic [CLIENTS*32-1:0]     stat_req_count,
  output logic [31:0]               stat_stall_cycles
`endif
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  logic [CLIENTS-1:0] elig;
  logic [CLIENTS-1:0] hs;
  logic [CLIENTS-1:0] sts_hit;
  logic [CL_W-1:0]    rr_ptr;
  logic [CL_W-1:0]    grant;
  logic               gnt_vld;
  logic               load;
  logic               take;
  logic               sts_in_range;
  logic               uf_now;
  logic               any_busy;
  logic [CNT_W-1:0]   outst     [CLIENTS];
  logic [CNT_W-1:0]   outst_nxt [CLIENTS];
  tag_split_t         sts_split;
  logic               unused_tag_hi;

  // A client competes only while it has credit left.
  always_comb begin
    elig = '0;
    for (int i = 0; i < CLIENTS; i++)
      elig[i] = s_req_valid[i] && (outst[i] < CNT_W'(MAX_OUTSTANDING));
  end

  cndm_micro_rr_arb #(.N(CLIENTS)) u_arb (
    .req     (elig),
    .ptr     (rr_ptr),
    .gnt_idx (grant),
    .gnt_vld (gnt_vld)
  );

  assign load = !m_req_valid || m_req_ready;
  assign take = load && gnt_vld && !rst;
  assign hs   = s_req_ready & s_req_valid;

  // Ready goes only to the granted client, and only when the slice can take it.
  always_comb begin
    s_req_ready = '0;
    if (take) s_req_ready[grant] = 1'b1;
  end

  // Split the engine tag; bits above TAG_W in the split tag are always zero.
  always_comb begin
    sts_split        = '0;
    sts_split.client = CL_MAX_W'(s_sts_tag[TAG_W+CL_W-1:TAG_W]);
    sts_split.tag    = TAG_MAX_W'(s_sts_tag[TAG_W-1:0]);
  end
  assign unused_tag_hi = ^sts_split.tag;
  assign sts_in_range  = 32'(sts_split.client) < CLIENTS;

  // Decode which client the incoming status belongs to.
  always_comb begin
    sts_hit = '0;
    for (int i = 0; i < CLIENTS; i++)
      sts_hit[i] = s_sts_valid && (32'(sts_split.client) == i);
  end

  // Credit update; a status for an idle client never decrements and flags underflow.
  always_comb begin
    uf_now   = s_sts_valid && !sts_in_range;
    any_busy = 1'b0;
    for (int i = 0; i < CLIENTS; i++) begin
      outst_nxt[i] = outst[i];
      if (hs[i] && !(sts_hit[i] && outst[i] != '0))
        outst_nxt[i] = outst[i] + 1'b1;
      else if (!hs[i] && sts_hit[i] && outst[i] != '0)
        outst_nxt[i] = outst[i] - 1'b1;
      if (sts_hit[i] && outst[i] == '0) uf_now = 1'b1;
      if (outst_nxt[i] != '0) any_busy = 1'b1;
    end
  end

  // Request register slice and round-robin pointer; holds while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_req_valid <= 1'b0;
      m_req_addr  <= '0;
      m_req_len   <= '0;
      m_req_tag   <= '0;
      rr_ptr      <= '0;
    end else if (load) begin
      m_req_valid <= take;
      if (take) begin
        m_req_addr <= s_req_addr[grant*ADDR_W +: ADDR_W];
        m_req_len  <= s_req_len[grant*LEN_W +: LEN_W];
        m_req_tag  <= {grant, s_req_tag[grant*TAG_W +: TAG_W]};
        rr_ptr     <= (grant == CL_W'(CLIENTS-1)) ? '0 : grant + 1'b1;
      end
    end
  end

  // Outstanding counters, busy flag and sticky underflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < CLIENTS; i++) outst[i] <= '0;
      busy          <= 1'b0;
      err_underflow <= 1'b0;
    end else begin
      for (int i = 0; i < CLIENTS; i++) outst[i] <= outst_nxt[i];
      busy          <= any_busy;
      err_underflow <= err_underflow | uf_now;
    end
  end

  // Registered status demux; out-of-range client indices are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_sts_valid <= '0;
      m_sts_tag   <= '0;
      m_sts_error <= 4'(DMA_ERR_OK);
    end else begin
      m_sts_valid <= sts_hit;
      m_sts_tag   <= sts_split.tag[TAG_W-1:0];
      m_sts_error <= s_sts_error;
    end
  end

`ifdef CNDM_DMA_RD_SCHED_STATS_EN
  // Per-client accepted-request counts and engine stall cycles, both wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_req_count    <= '0;
      stat_stall_cycles <= '0;
    end else begin
      for (int i = 0; i < CLIENTS; i++)
        stat_req_count[i*32 +: 32] <= stat_req_count[i*32 +: 32] + 32'(hs[i]);
      if (m_req_valid && !m_req_ready) stat_stall_cycles <= stat_stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: doc/cndm_micro_dma_rd_sched.md
Name: cndm_micro_dma_rd_sched

Overview:
- Schedules DMA read descriptor requests from CLIENTS requesters (per-port TX/RX queue managers) onto one shared DMA read engine.
- Round-robin grant with per-client outstanding-request credit limit.
- Client index is appended as tag MSBs on the way out; status is demultiplexed back by those MSBs.
- Sits between the per-port logic and the core-level DMA read descriptor channel.

Parameters:
CLIENTS, 2, number of requesters (>=2)
ADDR_W, 64, DMA source address width
LEN_W, 16, transfer length width
TAG_W, 8, client-side tag width
MAX_OUTSTANDING, 4, max in-flight requests per client (1..2**TAG_W)
CL_W, $clog2(CLIENTS), derived, client index width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
s_req_addr  in  CLIENTS*ADDR_W  per-client source address
s_req_len  in  CLIENTS*LEN_W  per-client length
s_req_tag  in  CLIENTS*TAG_W  per-client tag
s_req_valid  in  CLIENTS  request valid
s_req_ready  out  CLIENTS  request accepted
m_req_addr  out  ADDR_W  to DMA engine
m_req_len  out  LEN_W  to DMA engine
m_req_tag  out  TAG_W+CL_W  {client, tag}
m_req_valid  out  1  valid
m_req_ready  in  1  DMA engine ready
s_sts_tag  in  TAG_W+CL_W  completion tag from engine
s_sts_error  in  4  completion error code
s_sts_valid  in  1  completion strobe (no backpressure)
m_sts_tag  out  TAG_W  tag to selected client
m_sts_error  out  4  error to selected client
m_sts_valid  out  CLIENTS  one-hot completion strobe
busy  out  1  any client has outstanding requests
err_underflow  out  1  sticky: status received for client with zero outstanding

Behaviour:
- One clock domain: clk. Reset synchronous, active-high, on rst. Reset values: all s_req_ready, m_req_valid, m_sts_valid, busy, err_underflow = 0. Outstanding counters = 0. RR pointer = 0.
- Eligibility: client i is eligible when s_req_valid[i] and outst[i] < MAX_OUTSTANDING.
- Output stage: a single register slice. It is loadable when !m_req_valid || m_req_ready.
- When loadable and any client is eligible:
  - Grant one client by round-robin, searching upward from the RR pointer.
  - s_req_ready[grant] = 1 combinationally in that cycle; all other ready bits stay 0.
  - Next cycle: m_req_valid = 1; addr/len registered from that client; m_req_tag = {grant, s_req_tag[grant]}. Request latency is 1 cycle.
  - RR pointer becomes (grant+1) mod CLIENTS.
- If the stage is loadable and no client is eligible, m_req_valid deasserts after a handshake.
- m_req_* holds stable while m_req_valid && !m_req_ready.
- Counter update: outst[i] increments on the s_req handshake for client i. It decrements on s_sts_valid whose tag MSBs == i.
- Same-cycle increment and decrement on the same client: counter unchanged.
- Status path:
  - Registered, 1-cycle latency.
  - m_sts_valid[idx] pulses for 1 cycle; m_sts_tag = s_sts_tag[TAG_W-1:0]; m_sts_error passed through unchanged.
  - Back-to-back status each cycle is supported.
- Status for a client with outst == 0: still forwarded, counter stays 0, err_underflow set (cleared only by rst).
- Status with MSBs >= CLIENTS (non-power-of-2 CLIENTS): dropped, err_underflow set.
- busy = OR over clients of (outst != 0), registered.
- Counter width: $clog2(MAX_OUTSTANDING+1).
- rst mid-transfer: the in-flight m_req is discarded and counters are cleared. Late status after reset counts as underflow.

Optional Feature:
- Macro: CNDM_DMA_RD_SCHED_STATS_EN.
- When defined:
  - Adds output stat_req_count (CLIENTS*32): per-client accepted-request counters, wrapping at 2**32, reset to 0.
  - Adds output stat_stall_cycles (32): counts cycles with m_req_valid && !m_req_ready.
- When undefined: these ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package cndm_micro_pkg:
  - Typedef of the DMA error code (4-bit enum, 0 = OK).
  - Typedef of the tag-split struct {client, tag}.
- One sub-module, cndm_micro_rr_arb: combinational round-robin priority select.
  - Inputs: request vector, pointer.
  - Outputs: grant index and valid.
- Counters, register slice and status demux stay in the top level.

Test Plan:
- Single client 0 issues tag 0x05, addr 0x1000, len 64 -> m_req_tag = {0,0x05} one cycle later. Status tag {0,0x05} -> m_sts_valid = 01 with tag 0x05 one cycle later. busy goes 1 then 0.
- Both clients continuously valid, m_req_ready = 1 -> grants alternate 0,1,0,1; one accepted request per cycle.
- Client 1 issues 4 requests with no status (MAX_OUTSTANDING = 4) -> s_req_ready[1] stays 0. First status for client 1 -> the next request is accepted the following cycle.
- m_req_ready held 0 for 5 cycles with a request pending -> m_req_* stable and no s_req_ready pulses. With STATS_EN, stat_stall_cycles = 5.
- Same-cycle grant to client 0 and status for client 0 with outst = 2 -> outst stays 2.
- Status tag {1,0x00} with outst[1] = 0 -> m_sts_valid = 10 and err_underflow = 1. rst then clears err_underflow.
